// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the multiply/divide sequencer state encoding.
// Holds R-type funct codes for the ALU decoder and the HI/LO unit, plus the
// muldiv_seq FSM state type.
package mips_pkg;

  // ALU R-type funct codes
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;

  // HI/LO unit funct codes
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_core.sv
// One combinational iteration of the multiply/divide loop.
// Ports:
//   is_div           - 1: restoring-divide step, 0: shift-add multiply step
//   acc, low         - current {acc,low} pair (product hi/lo or remainder/quotient)
//   opb              - multiplicand or divisor (magnitudes)
//   acc_nxt, low_nxt - pair after this iteration
module muldiv_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] low_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_s;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic             unused_diff;

  // Multiply: add multiplicand when multiplier LSB set, then shift pair right.
  assign sum   = {1'b0, acc} + (low[0] ? {1'b0, opb} : '0);

  // Divide: shift {rem,quot} left, trial-subtract divisor, restore on borrow.
  assign rem_s = {acc, low[WIDTH-1]};
  assign diff  = {1'b0, rem_s} - {2'b00, opb};
  assign ge    = ~diff[WIDTH+1];
  // rem < divisor before the shift, so a successful difference fits in WIDTH bits
  assign unused_diff = diff[WIDTH];

  always_comb begin
    acc_nxt = sum[WIDTH:1];
    low_nxt = {sum[0], low[WIDTH-1:1]};
    if (is_div) begin
      acc_nxt = ge ? diff[WIDTH-1:0] : rem_s[WIDTH-1:0];
      low_nxt = {low[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU as a WIDTH-iteration loop on magnitudes, then fixes
// signs in a final cycle. MTHI/MTLO write HI/LO directly when idle.
// Optional: define MULDIV_FAST_MUL_EN to complete multiplies with a single-cycle
// multiplier (IDLE->FIX->IDLE); divides remain iterative.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   start, func  - EX-stage muldiv/MT* request and its funct code
//   rs_val, rt_val - operands A and B
//   cancel       - pipeline flush, aborts any in-flight operation
//   busy         - operation in flight (stall request)
//   hi, lo       - HI/LO registers
//   div_zero     - sticky flag: last completed divide had a zero divisor
module muldiv_seq
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ITER_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  md_state_e          state_q, state_d;
  logic [ITER_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d, low_q, low_d, opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic               dz_q, dz_d, div_zero_q, div_zero_d;

  logic               op_mul, op_div, op_signed;
  logic [WIDTH-1:0]   abs_a, abs_b, acc_step, low_step;
  logic [2*WIDTH-1:0] prod;

  assign op_mul    = (func == FUNCT_MULT) || (func == FUNCT_MULTU);
  assign op_div    = (func == FUNCT_DIV)  || (func == FUNCT_DIVU);
  assign op_signed = (func == FUNCT_MULT) || (func == FUNCT_DIV);
  assign abs_a     = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign abs_b     = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  assign prod      = {acc_q, low_q};

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = (2*WIDTH)'(abs_a) * (2*WIDTH)'(abs_b);
`endif

  muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .low     (low_q),
    .opb     (opb_q),
    .acc_nxt (acc_step),
    .low_nxt (low_step)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    low_d      = low_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      MD_IDLE: begin
        if (start && !cancel) begin
          if (op_mul || op_div) begin
            state_d   = MD_RUN;
            cnt_d     = '0;
            acc_d     = '0;
            is_div_d  = op_div;
            neg_d     = op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            rem_neg_d = op_signed && rs_val[WIDTH-1];
            dz_d      = op_div && (rt_val == '0);
            // Divide iterates on the dividend; multiply shifts the multiplier out.
            low_d     = op_div ? abs_a : abs_b;
            opb_d     = op_div ? abs_b : abs_a;
`ifdef MULDIV_FAST_MUL_EN
            if (op_mul) begin
              {acc_d, low_d} = fast_prod;
              state_d        = MD_FIX;
            end
`endif
          end else if (func == FUNCT_MTHI) begin
            hi_d = rs_val;
          end else if (func == FUNCT_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      MD_RUN: begin
        if (cancel) begin
          state_d = MD_IDLE;
        end else begin
          acc_d = acc_step;
          low_d = low_step;
          cnt_d = cnt_q + ITER_W'(1);
          if (cnt_q == ITER_W'(WIDTH - 1)) state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        if (!cancel) begin
          if (!is_div_q) begin
            {hi_d, lo_d} = neg_q ? -prod : prod;
          end else if (dz_q) begin
            // With a zero divisor the loop leaves |A| in the remainder; re-apply
            // the dividend sign to return the raw rs_val.
            lo_d       = '1;
            hi_d       = rem_neg_q ? -acc_q : acc_q;
            div_zero_d = 1'b1;
          end else begin
            lo_d       = neg_q ? -low_q : low_q;
            hi_d       = rem_neg_q ? -acc_q : acc_q;
            div_zero_d = 1'b0;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      low_q      <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      low_q      <= low_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != MD_IDLE);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_CYC = 1;
`else
  localparam int MUL_CYC = 33;
`endif
  localparam int DIV_CYC = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  func = 6'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_seq #(
    .WIDTH  (32),
    .ITER_W (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .func     (func),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .cancel   (cancel),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  // Issue one request and wait (bounded) for busy to drop; cyc = busy cycles seen.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk);
    start = 1'b1; func = f; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%0b exp=0", div_zero); end
  endtask

  task automatic test_mult;
    int cyc;
    run_op(F_MULT, 32'hFFFFFFFD, 32'd7, cyc);
    checks++; if (cyc != MUL_CYC) begin errors++; $display("FAIL mult_busy_cycles got=%0d exp=%0d", cyc, MUL_CYC); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo); end
    run_op(F_MULTU, 32'hFFFFFFFF, 32'd2, cyc);
    checks++; if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL multu_big got=%h_%h exp=00000001_fffffffe", hi, lo); end
    run_op(F_MULT, 32'h80000000, 32'h80000000, cyc);
    checks++; if (hi !== 32'h40000000 || lo !== 32'h0) begin
      errors++; $display("FAIL mult_intmin got=%h_%h exp=40000000_00000000", hi, lo); end
    run_op(F_MULT, 32'd6, 32'd7, cyc);
    checks++; if (cyc != MUL_CYC) begin errors++; $display("FAIL mult6x7_cycles got=%0d exp=%0d", cyc, MUL_CYC); end
    checks++; if (hi !== 32'h0 || lo !== 32'd42) begin
      errors++; $display("FAIL mult6x7 got=%h_%h exp=00000000_0000002a", hi, lo); end
  endtask

  task automatic test_div;
    int cyc;
    run_op(F_DIVU, 32'd100, 32'd7, cyc);
    checks++; if (cyc != DIV_CYC) begin errors++; $display("FAIL divu_cycles got=%0d exp=%0d", cyc, DIV_CYC); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin
      errors++; $display("FAIL divu_100_7 got hi=%h lo=%h exp hi=2 lo=e", hi, lo); end
    run_op(F_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div_m7_2 got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", hi, lo); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_m7_2_dz got=%0b exp=0", div_zero); end
    run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    checks++; if (lo !== 32'h80000000 || hi !== 32'h0) begin
      errors++; $display("FAIL div_intmin got hi=%h lo=%h exp hi=0 lo=80000000", hi, lo); end
  endtask

  task automatic test_div_zero;
    int cyc;
    run_op(F_DIVU, 32'h1234, 32'd0, cyc);
    checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'h1234) begin
      errors++; $display("FAIL divu_zero got hi=%h lo=%h exp hi=1234 lo=ffffffff", hi, lo); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL divu_zero_flag got=%0b exp=1", div_zero); end
    // multiply must not disturb the sticky flag
    run_op(F_MULTU, 32'd3, 32'd3, cyc);
    checks++; if (div_zero !== 1'b1 || lo !== 32'd9) begin
      errors++; $display("FAIL dz_after_mul got dz=%0b lo=%h exp dz=1 lo=9", div_zero, lo); end
    run_op(F_DIV, 32'd10, 32'd3, cyc);
    checks++; if (lo !== 32'd3 || hi !== 32'd1) begin
      errors++; $display("FAIL div_10_3 got hi=%h lo=%h exp hi=1 lo=3", hi, lo); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_10_3_dz got=%0b exp=0", div_zero); end
    run_op(F_DIV, 32'hFFFFFFF0, 32'd0, cyc);
    checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF0 || div_zero !== 1'b1) begin
      errors++; $display("FAIL div_neg_zero got hi=%h lo=%h dz=%0b exp hi=fffffff0 lo=ffffffff dz=1",
                         hi, lo, div_zero); end
  endtask

  task automatic test_cancel;
    int cyc;
    run_op(F_MTHI, 32'hAAAA, 32'd0, cyc);
    run_op(F_MTLO, 32'h5555, 32'd0, cyc);
    checks++; if (hi !== 32'hAAAA || lo !== 32'h5555) begin
      errors++; $display("FAIL mt_setup got hi=%h lo=%h exp hi=aaaa lo=5555", hi, lo); end
    @(negedge clk);
`ifdef MULDIV_FAST_MUL_EN
    start = 1'b1; func = F_DIVU; rs_val = 32'hFFFFFFFF; rt_val = 32'd3;
`else
    start = 1'b1; func = F_MULTU; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF;
`endif
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (busy && cyc < 10) begin
      cyc++;
      @(negedge clk);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cancel_busy10 got=%0b exp=1", busy); end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got=%0b exp=0", busy); end
    repeat (40) @(negedge clk);
    checks++; if (hi !== 32'hAAAA || lo !== 32'h5555) begin
      errors++; $display("FAIL cancel_hilo got hi=%h lo=%h exp hi=aaaa lo=5555", hi, lo); end
  endtask

  task automatic test_mt_busy;
    int cyc;
    bit saw_busy;
    @(negedge clk);
    start = 1'b1; func = F_DIV; rs_val = 32'd10; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; func = F_MTHI; rs_val = 32'hDEAD;
    @(negedge clk);
    func = F_MULT; rs_val = 32'd5; rt_val = 32'd5;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    checks++; if (cyc != DIV_CYC - 6) begin
      errors++; $display("FAIL busy_start_cycles got=%0d exp=%0d", cyc, DIV_CYC - 6); end
    checks++; if (hi !== 32'd1 || lo !== 32'd3) begin
      errors++; $display("FAIL mthi_busy got hi=%h lo=%h exp hi=1 lo=3", hi, lo); end
    // MTLO in IDLE: written at the next edge, busy never rises
    @(negedge clk);
    start = 1'b1; func = F_MTLO; rs_val = 32'hBEEF;
    @(negedge clk);
    start = 1'b0;
    checks++; if (lo !== 32'hBEEF || hi !== 32'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL mtlo got hi=%h lo=%h busy=%0b exp hi=1 lo=beef busy=0", hi, lo, busy); end
    // start + cancel together in IDLE: nothing happens
    start = 1'b1; cancel = 1'b1; func = F_MTHI; rs_val = 32'h1111;
    @(negedge clk);
    func = F_MULT; rs_val = 32'd2; rt_val = 32'd2;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    saw_busy = 1'b0;
    repeat (3) begin
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_busy || hi !== 32'd1 || lo !== 32'hBEEF) begin
      errors++; $display("FAIL start_cancel got busy=%0b hi=%h lo=%h exp busy=0 hi=1 lo=beef",
                         saw_busy, hi, lo); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    run_op(F_DIVU, 32'd5, 32'd0, cyc);
    checks++; if (div_zero !== 1'b1 || hi !== 32'd5) begin
      errors++; $display("FAIL rmid_setup got dz=%0b hi=%h exp dz=1 hi=5", div_zero, hi); end
    @(negedge clk);
    start = 1'b1; func = F_DIV; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || div_zero !== 1'b0) begin
      errors++; $display("FAIL reset_mid got busy=%0b hi=%h lo=%h dz=%0b exp all 0",
                         busy, hi, lo, div_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(F_DIVU, 32'd9, 32'd2, cyc);
    checks++; if (lo !== 32'd4 || hi !== 32'd1) begin
      errors++; $display("FAIL after_reset got hi=%h lo=%h exp hi=1 lo=4", hi, lo); end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_mult;
    test_div;
    test_div_zero;
    test_cancel;
    test_mt_busy;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
